// File: rtl/spi_byte_receiver.sv
// SPI slave-side byte receiver: synchronizes spi_clk/spi_cs_n/spi_in into clk,
// assembles MSB-first bytes and offers them on a valid/ready handshake.
module spi_byte_receiver #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_clk,
   input  logic       spi_cs_n,
   input  logic       spi_in,
   output logic [7:0] data_out,
   output logic       valid,
   input  logic       ready,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy
);

   typedef enum logic {
      IDLE,
      RECV
   } state_t;

   state_t                 state, state_next;
   logic [SYNC_STAGES-1:0] clk_sync, cs_sync, in_sync;
   logic                   prev_clk;
   logic                   sclk, cs_s, din, rise;
   logic [2:0]             bit_cnt, bit_cnt_next;
   logic [7:0]             shift_reg, shift_next;
   logic [7:0]             data_next;
   logic                   valid_next, overrun_next, frame_err_next;
   logic                   byte_done;

   // Input synchronizers plus previous-level flop for spi_clk edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync <= '0;
         cs_sync  <= '1;
         in_sync  <= '0;
         prev_clk <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         in_sync  <= {in_sync[SYNC_STAGES-2:0], spi_in};
         prev_clk <= sclk;
      end
   end

   assign sclk = clk_sync[SYNC_STAGES-1];
   assign cs_s = cs_sync[SYNC_STAGES-1];
   assign din  = in_sync[SYNC_STAGES-1];
   assign rise = sclk & ~prev_clk;
   assign busy = ~cs_s;

   // State, bit counter, shifter and handshake registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         data_out  <= '0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_next;
         bit_cnt   <= bit_cnt_next;
         shift_reg <= shift_next;
         data_out  <= data_next;
         valid     <= valid_next;
         overrun   <= overrun_next;
         frame_err <= frame_err_next;
      end
   end

   // Framing, byte completion, overrun/frame-error detection and consumption
   always_comb begin
      state_next     = cs_s ? IDLE : RECV;
      bit_cnt_next   = bit_cnt;
      shift_next     = shift_reg;
      data_next      = data_out;
      valid_next     = valid;
      overrun_next   = 1'b0;
      frame_err_next = 1'b0;
      byte_done      = 1'b0;

      if (cs_s) begin
         // A rise coinciding with chip-select release is deliberately ignored here
         if (state == RECV && bit_cnt != 3'd0)
            frame_err_next = 1'b1;
         bit_cnt_next = '0;
         shift_next   = '0;
      end else if (rise) begin
         shift_next   = {shift_reg[6:0], din};
         bit_cnt_next = bit_cnt + 3'd1;
         if (bit_cnt == 3'd7) begin
            if (!valid || ready) begin
               data_next  = {shift_reg[6:0], din};
               valid_next = 1'b1;
               byte_done  = 1'b1;
            end else begin
               overrun_next = 1'b1;
            end
         end
      end

      if (valid && ready && !byte_done)
         valid_next = 1'b0;
   end

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Directed self-checking bench for spi_byte_receiver.
module tb_spi_byte_receiver;

   localparam int unsigned HALF = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_clk;
   logic       spi_cs_n;
   logic       spi_in;
   logic [7:0] data_out;
   logic       valid;
   logic       ready;
   logic       overrun;
   logic       frame_err;
   logic       busy;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned ovr_cnt  = 0;
   int unsigned ferr_cnt = 0;
   logic [7:0]  got_q[$];
   int unsigned lat;

   spi_byte_receiver #(.SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .spi_clk   (spi_clk),
      .spi_cs_n  (spi_cs_n),
      .spi_in    (spi_in),
      .data_out  (data_out),
      .valid     (valid),
      .ready     (ready),
      .overrun   (overrun),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Record accepted bytes and error pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (valid && ready) got_q.push_back(data_out);
      if (overrun)   ovr_cnt++;
      if (frame_err) ferr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic wait_clk(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      spi_in = b;
      wait_clk(HALF);
      spi_clk = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] v, input int unsigned n);
      for (int i = 7; i > 7 - int'(n); i--) send_bit(v[i]);
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic cs_high();
      wait_clk(HALF);
      spi_cs_n = 1'b1;
      wait_clk(HALF);
   endtask

   initial begin
      rst = 1'b0; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_in = 1'b0; ready = 1'b0;
      wait_clk(3);
      check("rst_data", data_out, 8'h00);
      check("rst_valid", valid, 0);
      check("rst_overrun", overrun, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_busy", busy, 0);
      rst = 1'b1;
      wait_clk(2);

      // Single byte 0xA5 with latency measurement on the 8th edge
      ready = 1'b1; ovr_cnt = 0; ferr_cnt = 0; got_q.delete();
      cs_low();
      check("busy_active", busy, 1);
      send_bits(8'hA5, 7);
      spi_in = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b1;
      lat = 0;
      while (!valid && lat < 10) begin
         wait_clk(1);
         lat++;
      end
      check("single_latency", lat, 3);
      check("single_data", data_out, 8'hA5);
      wait_clk(1);
      check("single_valid_clear", valid, 0);
      wait_clk(2);
      spi_clk = 1'b0;
      wait_clk(HALF);
      cs_high();
      check("single_overrun", ovr_cnt, 0);
      check("single_frame_err", ferr_cnt, 0);
      check("busy_idle", busy, 0);

      // Back-to-back bytes in one frame
      got_q.delete();
      cs_low();
      send_bits(8'h01, 8);
      send_bits(8'h02, 8);
      cs_high();
      check("b2b_count", got_q.size(), 2);
      check("b2b_first", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h01);
      check("b2b_second", (got_q.size() > 1) ? got_q[1] : 8'hxx, 8'h02);
      check("b2b_frame_err", ferr_cnt, 0);

      // Overrun: consumer stalled across two completions
      ready = 1'b0; ovr_cnt = 0;
      cs_low();
      send_bits(8'h11, 8);
      send_bits(8'h22, 8);
      cs_high();
      check("ovr_data", data_out, 8'h11);
      check("ovr_valid", valid, 1);
      check("ovr_pulses", ovr_cnt, 1);
      ready = 1'b1;
      wait_clk(1);
      ready = 1'b0;
      check("ovr_valid_clear", valid, 0);

      // Consume 0x33 on exactly the edge 0x44 completes
      ovr_cnt = 0;
      cs_low();
      send_bits(8'h33, 8);
      send_bits(8'h44, 7);
      spi_in = 1'b0;
      wait_clk(HALF);
      spi_clk = 1'b1;
      wait_clk(2);
      ready = 1'b1;
      wait_clk(1);
      ready = 1'b0;
      check("simul_data", data_out, 8'h44);
      check("simul_valid", valid, 1);
      wait_clk(1);
      spi_clk = 1'b0;
      wait_clk(HALF);
      cs_high();
      check("simul_overrun", ovr_cnt, 0);
      ready = 1'b1;
      wait_clk(2);

      // Frame ends after 3 bits, then a clean 0x3C frame
      got_q.delete(); ferr_cnt = 0;
      cs_low();
      send_bits(8'hA0, 3);
      cs_high();
      check("ferr_pulses", ferr_cnt, 1);
      check("ferr_no_byte", got_q.size(), 0);
      cs_low();
      send_bits(8'h3C, 8);
      cs_high();
      check("ferr_next_count", got_q.size(), 1);
      check("ferr_next_data", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h3C);

      // Asynchronous reset mid-byte with a pending byte
      ready = 1'b0;
      cs_low();
      send_bits(8'h5A, 8);
      send_bits(8'hF8, 5);
      check("pre_rst_valid", valid, 1);
      rst = 1'b0;
      #1;
      check("async_rst_data", data_out, 8'h00);
      check("async_rst_valid", valid, 0);
      check("async_rst_busy", busy, 0);
      spi_cs_n = 1'b1;
      wait_clk(3);
      rst = 1'b1;
      wait_clk(2);
      ready = 1'b1; got_q.delete(); ferr_cnt = 0;
      cs_low();
      send_bits(8'hC3, 8);
      cs_high();
      check("post_rst_count", got_q.size(), 1);
      check("post_rst_data", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'hC3);
      check("post_rst_frame_err", ferr_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
